// File: rtl/smul_r16_iter.sv
`default_nettype none
// ============================================================================
// Module      : smul_r16_iter
// Description : Iterative unsigned 64x64->128 multiplier. Retires one radix-16
//               digit of B per cycle, least-significant digit first. The
//               latched multiplicand is driven out on a_q to an external
//               odd-multiple precompute stage. That stage returns 3A..15A
//               combinationally, and one partial product is selected and
//               accumulated per cycle. The operation exits early once all
//               remaining digits of B are zero.
// Ports       :
//   clk        in   1    clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    operands offered
//   in_ready   out  1    block can accept operands (IDLE)
//   in_a       in   64   multiplicand A
//   in_b       in   64   multiplier B
//   kill       in   1    abort current operation (flush)
//   a_q        out  65   latched A, zero-extended, to precompute
//   m3..m15    in   68   odd multiples of a_q from precompute
//   out_valid  out  1    product valid (DONE)
//   out_ready  in   1    consumer takes product
//   out_prod   out  PW   A*B
// Revision    : 1.0 - initial release
// ============================================================================
module smul_r16_iter #(
    parameter int NDIG = 16,
    parameter int PW   = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_a,
    input  logic [63:0]   in_b,
    input  logic          kill,
    output logic [64:0]   a_q,
    input  logic [67:0]   m3,
    input  logic [67:0]   m5,
    input  logic [67:0]   m7,
    input  logic [67:0]   m9,
    input  logic [67:0]   m11,
    input  logic [67:0]   m13,
    input  logic [67:0]   m15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_prod
);

    localparam int          CW     = $clog2(NDIG);
    localparam int          ACCW   = PW + 4;
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [64:0]     a_d;
    logic [63:0]     b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;

    logic [CW+1:0]   w_shamt;
    logic [63:0]     w_b_hi;
    logic [3:0]      w_digit;
    logic            w_upper_zero;
    logic [67:0]     w_a68;
    logic [67:0]     w_pp;
    logic [ACCW-1:0] w_pp_sh;
    logic [3:0]      acc_top_unused;

    // B is kept unshifted; the current digit and the early-exit test both
    // come from B shifted down to the current digit position.
    assign w_shamt      = {cnt_q, 2'b00};
    assign w_b_hi       = b_q >> w_shamt;
    assign w_digit      = w_b_hi[3:0];
    assign w_upper_zero = (w_b_hi[63:4] == 60'd0);
    assign w_a68        = {3'b000, a_q};

    // Even digits reuse a smaller odd multiple shifted left; the shifted-out
    // bits are zero because a_q[64] is always zero.
    always_comb begin
        w_pp = '0;
        case (w_digit)
            4'd0:  w_pp = '0;
            4'd1:  w_pp = w_a68;
            4'd2:  w_pp = {w_a68[66:0], 1'b0};
            4'd3:  w_pp = m3;
            4'd4:  w_pp = {w_a68[65:0], 2'b00};
            4'd5:  w_pp = m5;
            4'd6:  w_pp = {m3[66:0], 1'b0};
            4'd7:  w_pp = m7;
            4'd8:  w_pp = {w_a68[64:0], 3'b000};
            4'd9:  w_pp = m9;
            4'd10: w_pp = {m5[66:0], 1'b0};
            4'd11: w_pp = m11;
            4'd12: w_pp = {m3[65:0], 2'b00};
            4'd13: w_pp = m13;
            4'd14: w_pp = {m7[66:0], 1'b0};
            4'd15: w_pp = m15;
            default: w_pp = '0;
        endcase
    end

    assign w_pp_sh = {{(ACCW-68){1'b0}}, w_pp} << w_shamt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                // kill blocks acceptance even though in_ready is high
                if (in_valid && !kill) begin
                    a_d     = {1'b0, in_a};
                    b_d     = in_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_q + w_pp_sh;
                    cnt_d = cnt_q + CW'(1);
                    if ((cnt_q == C_LAST) || w_upper_zero) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (kill || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_prod  = acc_q[PW-1:0];

    // Guard bits above the product; always zero for 64-bit operands.
    assign acc_top_unused = acc_q[ACCW-1:PW];

endmodule
`default_nettype wire
